// File: rtl/mem_stage_if.sv
// ----------------------------------------------------------------------------
// mem_stage_if
// Pipeline handshake bundle around the memory stage.
//   ES -> MS link : es_to_ms_valid, es_to_ms_bus[73:0], ms_allowin (back)
//   MS -> WS link : ms_to_ws_valid, ms_to_ws_bus[69:0], ws_allowin (back)
// Modports:
//   slave  : the memory stage itself
//   master : the surrounding pipeline (execute/writeback side or a bench)
// ----------------------------------------------------------------------------
interface mem_stage_if;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [73:0] es_to_ms_bus;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;

    modport slave (
        output ms_allowin,
        input  es_to_ms_valid,
        input  es_to_ms_bus,
        input  ws_allowin,
        output ms_to_ws_valid,
        output ms_to_ws_bus
    );

    modport master (
        input  ms_allowin,
        output es_to_ms_valid,
        output es_to_ms_bus,
        output ws_allowin,
        input  ms_to_ws_valid,
        input  ms_to_ws_bus
    );
endinterface

// File: rtl/mem_stage.sv
// ----------------------------------------------------------------------------
// mem_stage
// Memory stage of the in-order pipeline: latches the execute-stage bus,
// extracts/extends load data and forwards the result to writeback and decode.
//
// Ports:
//   clk                   sole clock, posedge
//   reset                 synchronous, active-high
//   ms_stall              hold stage contents
//   ms_flush              squash stage contents (wins over stall and accept)
//   pipe (slave)          ES->MS and MS->WS handshakes, see mem_stage_if
//   data_sram_rdata[31:0] load data from data SRAM
//   data_sram_data_ok     response strobe (only with MS_DATA_OK_WAIT_EN)
//   ms_to_ds_forward_bus  {load_pending, fwd_en, dest[4:0], result[31:0]}
//
// Build option: define MS_DATA_OK_WAIT_EN to make loads wait for
// data_sram_data_ok (with response buffering and stale-response discard).
// Without it the load data is taken combinationally in the MS cycle.
// ----------------------------------------------------------------------------
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        ms_stall,
    input  logic        ms_flush,
    mem_stage_if.slave  pipe,
    input  logic [31:0] data_sram_rdata,
    input  logic        data_sram_data_ok,
    output logic [38:0] ms_to_ds_forward_bus
);
    logic        r_ms_valid;
    logic [73:0] r_bus;

    logic        w_res_from_mem;
    logic [2:0]  w_ld_type;
    logic        w_gr_we;
    logic [4:0]  w_dest;
    logic [31:0] w_alu_result;
    logic [31:0] w_pc;
    logic        w_ready_go;
    logic        w_leave;
    logic [31:0] w_load_word;
    logic [7:0]  w_byte [4];
    logic [7:0]  w_sel_byte;
    logic [15:0] w_sel_half;
    logic [31:0] w_load_ext;
    logic [31:0] w_final_result;
    logic        w_fwd_en;
    logic        w_load_pending;

    assign w_res_from_mem = r_bus[73];
    assign w_ld_type      = r_bus[72:70];
    assign w_gr_we        = r_bus[69];
    assign w_dest         = r_bus[68:64];
    assign w_alu_result   = r_bus[63:32];
    assign w_pc           = r_bus[31:0];

`ifdef MS_DATA_OK_WAIT_EN
    logic        r_data_ok_seen;
    logic        r_discard;
    logic [31:0] r_rdata_buf;
    logic        w_rsp_ok;

    // A response is ours only if no flushed load is still owed one.
    assign w_rsp_ok    = data_sram_data_ok && !r_discard;
    assign w_ready_go  = !w_res_from_mem || r_data_ok_seen || w_rsp_ok;
    assign w_load_word = r_data_ok_seen ? r_rdata_buf : data_sram_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_ok_seen <= 1'b0;
            r_discard      <= 1'b0;
            r_rdata_buf    <= 32'd0;
        end else if (ms_flush) begin
            r_data_ok_seen <= 1'b0;
            // A flushed load whose response is still outstanding leaves one
            // response in flight that must be swallowed later.
            if (r_ms_valid && w_res_from_mem && !r_data_ok_seen && !w_rsp_ok)
                r_discard <= 1'b1;
            else if (data_sram_data_ok)
                r_discard <= 1'b0;
        end else begin
            if (data_sram_data_ok && r_discard)
                r_discard <= 1'b0;
            else if (w_rsp_ok && r_ms_valid && w_res_from_mem &&
                     !r_data_ok_seen && !w_leave) begin
                r_rdata_buf    <= data_sram_rdata;
                r_data_ok_seen <= 1'b1;
            end
            if (w_leave)
                r_data_ok_seen <= 1'b0;
        end
    end
`else
    logic w_unused_data_ok;
    assign w_unused_data_ok = data_sram_data_ok;
    assign w_ready_go       = 1'b1;
    assign w_load_word      = data_sram_rdata;
`endif

    // Byte lanes of the load word, picked by the low address bits.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_byte[gi] = w_load_word[8*gi +: 8];
        end
    endgenerate

    assign w_sel_byte = w_byte[w_alu_result[1:0]];
    assign w_sel_half = w_alu_result[1] ? w_load_word[31:16] : w_load_word[15:0];

    always_comb begin
        w_load_ext = w_load_word;
        case (w_ld_type)
            3'b001:  w_load_ext = {{24{w_sel_byte[7]}}, w_sel_byte};
            3'b010:  w_load_ext = {{16{w_sel_half[15]}}, w_sel_half};
            3'b011:  w_load_ext = {24'd0, w_sel_byte};
            3'b100:  w_load_ext = {16'd0, w_sel_half};
            default: w_load_ext = w_load_word;
        endcase
    end

    assign w_final_result = w_res_from_mem ? w_load_ext : w_alu_result;

    assign pipe.ms_allowin     = (!r_ms_valid || (w_ready_go && pipe.ws_allowin)) && !ms_stall;
    assign pipe.ms_to_ws_valid = r_ms_valid && w_ready_go && !ms_stall;
    assign pipe.ms_to_ws_bus   = {w_gr_we, w_dest, w_final_result, w_pc};
    assign w_leave             = pipe.ms_to_ws_valid && pipe.ws_allowin;

    assign w_fwd_en       = r_ms_valid && w_gr_we && (w_dest != 5'd0) && w_ready_go;
    assign w_load_pending = r_ms_valid && w_res_from_mem && w_gr_we &&
                            (w_dest != 5'd0) && !w_ready_go;
    assign ms_to_ds_forward_bus = {w_load_pending, w_fwd_en, w_dest, w_final_result};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ms_valid <= 1'b0;
            r_bus      <= 74'd0;
        end else if (ms_flush) begin
            r_ms_valid <= 1'b0;
            r_bus      <= 74'd0;
        end else if (pipe.ms_allowin) begin
            r_ms_valid <= pipe.es_to_ms_valid;
            if (pipe.es_to_ms_valid)
                r_bus <= pipe.es_to_ms_bus;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    logic        clk;
    logic        reset;
    logic        ms_stall;
    logic        ms_flush;
    logic [31:0] data_sram_rdata;
    logic        data_sram_data_ok;
    logic [38:0] ms_to_ds_forward_bus;

    int n_cmp;
    int n_err;

    mem_stage_if u_if();

    mem_stage dut (
        .clk                  (clk),
        .reset                (reset),
        .ms_stall             (ms_stall),
        .ms_flush             (ms_flush),
        .pipe                 (u_if),
        .data_sram_rdata      (data_sram_rdata),
        .data_sram_data_ok    (data_sram_data_ok),
        .ms_to_ds_forward_bus (ms_to_ds_forward_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [73:0] mk_bus(input logic rm, input logic [2:0] lt,
                                           input logic we, input logic [4:0] dst,
                                           input logic [31:0] alu, input logic [31:0] pc);
        return {rm, lt, we, dst, alu, pc};
    endfunction

    function automatic logic [69:0] mk_ws(input logic we, input logic [4:0] dst,
                                          input logic [31:0] res, input logic [31:0] pc);
        return {we, dst, res, pc};
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        u_if.es_to_ms_valid = 1'b1;
        u_if.es_to_ms_bus   = mk_bus(1'b1, 3'd0, 1'b1, 5'd9, 32'h1234, 32'h1c00_0000);
        @(negedge clk); #1;
        n_cmp++; if (u_if.ms_allowin !== 1'b1) begin n_err++; $display("FAIL reset_allowin: got %b want 1", u_if.ms_allowin); end
        n_cmp++; if (u_if.ms_to_ws_valid !== 1'b0) begin n_err++; $display("FAIL reset_ws_valid: got %b want 0", u_if.ms_to_ws_valid); end
        n_cmp++; if (ms_to_ds_forward_bus !== 39'd0) begin n_err++; $display("FAIL reset_fwd: got %h want 0", ms_to_ds_forward_bus); end
        @(negedge clk);
        reset = 1'b0;
        u_if.es_to_ms_valid = 1'b0;
        #1;
        n_cmp++; if (u_if.ms_to_ws_valid !== 1'b0) begin n_err++; $display("FAIL reset_hold_valid: got %b want 0", u_if.ms_to_ws_valid); end
    endtask

    task automatic test_loads;
        logic [2:0]  v_typ  [10];
        logic [31:0] v_alu  [10];
        logic [31:0] v_rd   [10];
        logic [31:0] v_exp  [10];
        logic [31:0] pc;
        v_typ = '{3'd1, 3'd4, 3'd2, 3'd3, 3'd1, 3'd0, 3'd7, 3'd2, 3'd1, 3'd3};
        v_alu = '{32'h1003, 32'h2002, 32'h2002, 32'h1001, 32'h1002,
                  32'h2003, 32'h0001, 32'h0000, 32'h0000, 32'h0003};
        v_rd  = '{32'h80FF_1234, 32'h8001_7FFF, 32'h8001_7FFF, 32'h80FF_1234, 32'h80FF_1234,
                  32'h8001_7FFF, 32'h1234_5678, 32'h8001_7FFF, 32'h80FF_1234, 32'h80FF_1234};
        v_exp = '{32'hFFFF_FF80, 32'h0000_8001, 32'hFFFF_8001, 32'h0000_0012, 32'hFFFF_FFFF,
                  32'h8001_7FFF, 32'h1234_5678, 32'h0000_7FFF, 32'h0000_0034, 32'h0000_0080};
        u_if.ws_allowin = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pc = 32'h1c00_0100 + 32'(4 * i);
            @(negedge clk);
            u_if.es_to_ms_valid = 1'b1;
            u_if.es_to_ms_bus   = mk_bus(1'b1, v_typ[i], 1'b1, 5'd9, v_alu[i], pc);
            data_sram_data_ok   = 1'b0;
            #1;
            n_cmp++; if (u_if.ms_allowin !== 1'b1) begin n_err++; $display("FAIL load%0d_allowin: got %b want 1", i, u_if.ms_allowin); end
            @(negedge clk);
            u_if.es_to_ms_valid = 1'b0;
            data_sram_rdata     = v_rd[i];
            data_sram_data_ok   = 1'b1;
            #1;
            n_cmp++; if (u_if.ms_to_ws_valid !== 1'b1) begin n_err++; $display("FAIL load%0d_valid: got %b want 1", i, u_if.ms_to_ws_valid); end
            n_cmp++; if (u_if.ms_to_ws_bus !== mk_ws(1'b1, 5'd9, v_exp[i], pc)) begin n_err++; $display("FAIL load%0d_bus: got %h want %h", i, u_if.ms_to_ws_bus, mk_ws(1'b1, 5'd9, v_exp[i], pc)); end
            n_cmp++; if (ms_to_ds_forward_bus !== {1'b0, 1'b1, 5'd9, v_exp[i]}) begin n_err++; $display("FAIL load%0d_fwd: got %h want %h", i, ms_to_ds_forward_bus, {1'b0, 1'b1, 5'd9, v_exp[i]}); end
            @(negedge clk);
            data_sram_rdata   = 32'd0;
            data_sram_data_ok = 1'b0;
            #1;
            n_cmp++; if (u_if.ms_to_ws_valid !== 1'b0) begin n_err++; $display("FAIL load%0d_gone: got %b want 0", i, u_if.ms_to_ws_valid); end
        end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        u_if.ws_allowin     = 1'b0;
        u_if.es_to_ms_valid = 1'b1;
        u_if.es_to_ms_bus   = mk_bus(1'b0, 3'd0, 1'b1, 5'd5, 32'h55, 32'h1c00_0200);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            u_if.es_to_ms_bus = mk_bus(1'b0, 3'd0, 1'b1, 5'd6, 32'h66, 32'h1c00_0204);
            data_sram_rdata   = $urandom;
            #1;
            n_cmp++; if (u_if.ms_to_ws_valid !== 1'b1) begin n_err++; $display("FAIL bp%0d_valid: got %b want 1", c, u_if.ms_to_ws_valid); end
            n_cmp++; if (u_if.ms_to_ws_bus !== mk_ws(1'b1, 5'd5, 32'h55, 32'h1c00_0200)) begin n_err++; $display("FAIL bp%0d_bus: got %h", c, u_if.ms_to_ws_bus); end
            n_cmp++; if (u_if.ms_allowin !== 1'b0) begin n_err++; $display("FAIL bp%0d_allowin: got %b want 0", c, u_if.ms_allowin); end
            n_cmp++; if (ms_to_ds_forward_bus !== {1'b0, 1'b1, 5'd5, 32'h55}) begin n_err++; $display("FAIL bp%0d_fwd: got %h", c, ms_to_ds_forward_bus); end
        end
        @(negedge clk);
        u_if.ws_allowin = 1'b1;
        #1;
        n_cmp++; if (u_if.ms_allowin !== 1'b1) begin n_err++; $display("FAIL bp_release_allowin: got %b want 1", u_if.ms_allowin); end
        @(negedge clk);
        u_if.es_to_ms_valid = 1'b0;
        #1;
        n_cmp++; if (u_if.ms_to_ws_bus !== mk_ws(1'b1, 5'd6, 32'h66, 32'h1c00_0204)) begin n_err++; $display("FAIL bp_next_bus: got %h", u_if.ms_to_ws_bus); end
        @(negedge clk); #1;
        n_cmp++; if (u_if.ms_to_ws_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %b want 0", u_if.ms_to_ws_valid); end
    endtask

    task automatic test_stall;
        @(negedge clk);
        u_if.es_to_ms_valid = 1'b1;
        u_if.es_to_ms_bus   = mk_bus(1'b0, 3'd0, 1'b1, 5'd3, 32'h1234, 32'h1c00_0300);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            ms_stall          = 1'b1;
            u_if.es_to_ms_bus = mk_bus(1'b0, 3'd0, 1'b1, 5'd4, 32'h9999, 32'h1c00_0304);
            #1;
            n_cmp++; if (u_if.ms_to_ws_valid !== 1'b0) begin n_err++; $display("FAIL stall%0d_valid: got %b want 0", c, u_if.ms_to_ws_valid); end
            n_cmp++; if (u_if.ms_allowin !== 1'b0) begin n_err++; $display("FAIL stall%0d_allowin: got %b want 0", c, u_if.ms_allowin); end
            n_cmp++; if (ms_to_ds_forward_bus !== {1'b0, 1'b1, 5'd3, 32'h1234}) begin n_err++; $display("FAIL stall%0d_fwd: got %h", c, ms_to_ds_forward_bus); end
        end
        @(negedge clk);
        ms_stall            = 1'b0;
        u_if.es_to_ms_valid = 1'b0;
        #1;
        n_cmp++; if (u_if.ms_to_ws_bus !== mk_ws(1'b1, 5'd3, 32'h1234, 32'h1c00_0300) || u_if.ms_to_ws_valid !== 1'b1) begin n_err++; $display("FAIL stall_release: got %b/%h", u_if.ms_to_ws_valid, u_if.ms_to_ws_bus); end
        @(negedge clk); #1;
        n_cmp++; if (u_if.ms_to_ws_valid !== 1'b0) begin n_err++; $display("FAIL stall_drain: got %b want 0", u_if.ms_to_ws_valid); end
    endtask

    task automatic test_flush;
        @(negedge clk);
        u_if.es_to_ms_valid = 1'b1;
        u_if.es_to_ms_bus   = mk_bus(1'b0, 3'd0, 1'b1, 5'd10, 32'hAAAA, 32'h1c00_0400);
        @(negedge clk);
        ms_flush          = 1'b1;
        u_if.es_to_ms_bus = mk_bus(1'b0, 3'd0, 1'b1, 5'd11, 32'hBBBB, 32'h1c00_0404);
        @(negedge clk);
        ms_flush            = 1'b0;
        u_if.es_to_ms_valid = 1'b0;
        #1;
        n_cmp++; if (u_if.ms_to_ws_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", u_if.ms_to_ws_valid); end
        n_cmp++; if (ms_to_ds_forward_bus !== 39'd0) begin n_err++; $display("FAIL flush_fwd: got %h want 0", ms_to_ds_forward_bus); end
        @(negedge clk);
        u_if.es_to_ms_valid = 1'b1;
        u_if.es_to_ms_bus   = mk_bus(1'b0, 3'd0, 1'b1, 5'd12, 32'hCCCC, 32'h1c00_0408);
        @(negedge clk);
        u_if.es_to_ms_valid = 1'b0;
        ms_stall = 1'b1;
        ms_flush = 1'b1;
        @(negedge clk);
        ms_stall = 1'b0;
        ms_flush = 1'b0;
        #1;
        n_cmp++; if (u_if.ms_to_ws_valid !== 1'b0) begin n_err++; $display("FAIL flush_stall_valid: got %b want 0", u_if.ms_to_ws_valid); end
        n_cmp++; if (ms_to_ds_forward_bus !== 39'd0) begin n_err++; $display("FAIL flush_stall_fwd: got %h want 0", ms_to_ds_forward_bus); end
        n_cmp++; if (u_if.ms_allowin !== 1'b1) begin n_err++; $display("FAIL flush_stall_allowin: got %b want 1", u_if.ms_allowin); end
    endtask

    task automatic test_back_to_back;
        logic        v_we  [4];
        logic [4:0]  v_dst [4];
        logic [31:0] v_alu [4];
        logic        v_fen [4];
        logic [31:0] pc;
        v_we  = '{1'b1, 1'b0, 1'b1, 1'b1};
        v_dst = '{5'd1, 5'd2, 5'd0, 5'd31};
        v_alu = '{32'h10, 32'h20, 32'h30, 32'hFFFF_0000};
        v_fen = '{1'b1, 1'b0, 1'b0, 1'b1};
        u_if.ws_allowin = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            u_if.es_to_ms_valid = (i < 4);
            if (i < 4)
                u_if.es_to_ms_bus = mk_bus(1'b0, 3'd0, v_we[i], v_dst[i], v_alu[i], 32'h1c00_0500 + 32'(4 * i));
            #1;
            if (i > 0) begin
                pc = 32'h1c00_0500 + 32'(4 * (i - 1));
                n_cmp++; if (u_if.ms_to_ws_valid !== 1'b1 || u_if.ms_to_ws_bus !== mk_ws(v_we[i-1], v_dst[i-1], v_alu[i-1], pc)) begin n_err++; $display("FAIL b2b%0d_bus: got %b/%h", i - 1, u_if.ms_to_ws_valid, u_if.ms_to_ws_bus); end
                n_cmp++; if (ms_to_ds_forward_bus[37] !== v_fen[i-1]) begin n_err++; $display("FAIL b2b%0d_fwd_en: got %b want %b", i - 1, ms_to_ds_forward_bus[37], v_fen[i-1]); end
            end
        end
        @(negedge clk); #1;
        n_cmp++; if (u_if.ms_to_ws_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b want 0", u_if.ms_to_ws_valid); end
    endtask

`ifdef MS_DATA_OK_WAIT_EN
    task automatic test_data_ok_wait;
        @(negedge clk);
        u_if.ws_allowin     = 1'b0;
        u_if.es_to_ms_valid = 1'b1;
        u_if.es_to_ms_bus   = mk_bus(1'b1, 3'd0, 1'b1, 5'd7, 32'h300, 32'h1c00_0600);
        data_sram_data_ok   = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            u_if.es_to_ms_valid = 1'b0;
            #1;
            n_cmp++; if (ms_to_ds_forward_bus[38] !== 1'b1 || u_if.ms_to_ws_valid !== 1'b0) begin n_err++; $display("FAIL wait%0d_pending: got fwd %h valid %b", c, ms_to_ds_forward_bus, u_if.ms_to_ws_valid); end
        end
        @(negedge clk);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (u_if.ms_to_ws_valid !== 1'b1 || ms_to_ds_forward_bus[38] !== 1'b0) begin n_err++; $display("FAIL wait_rsp: got valid %b fwd %h", u_if.ms_to_ws_valid, ms_to_ds_forward_bus); end
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        #1;
        n_cmp++; if (u_if.ms_to_ws_bus !== mk_ws(1'b1, 5'd7, 32'hDEAD_BEEF, 32'h1c00_0600)) begin n_err++; $display("FAIL wait_buffered: got %h", u_if.ms_to_ws_bus); end
        @(negedge clk);
        u_if.ws_allowin = 1'b1;
        #1;
        n_cmp++; if (u_if.ms_to_ws_valid !== 1'b1 || u_if.ms_to_ws_bus !== mk_ws(1'b1, 5'd7, 32'hDEAD_BEEF, 32'h1c00_0600)) begin n_err++; $display("FAIL wait_deliver: got %b/%h", u_if.ms_to_ws_valid, u_if.ms_to_ws_bus); end
        @(negedge clk); #1;
        n_cmp++; if (u_if.ms_to_ws_valid !== 1'b0) begin n_err++; $display("FAIL wait_drain: got %b want 0", u_if.ms_to_ws_valid); end
    endtask

    task automatic test_discard;
        @(negedge clk);
        u_if.ws_allowin     = 1'b1;
        u_if.es_to_ms_valid = 1'b1;
        u_if.es_to_ms_bus   = mk_bus(1'b1, 3'd0, 1'b1, 5'd7, 32'h380, 32'h1c00_0700);
        @(negedge clk);
        ms_flush          = 1'b1;
        u_if.es_to_ms_bus = mk_bus(1'b0, 3'd0, 1'b1, 5'd2, 32'h22, 32'h1c00_0704);
        #1;
        n_cmp++; if (ms_to_ds_forward_bus[38] !== 1'b1) begin n_err++; $display("FAIL disc_pending: got %b want 1", ms_to_ds_forward_bus[38]); end
        @(negedge clk);
        ms_flush          = 1'b0;
        u_if.ws_allowin   = 1'b0;
        u_if.es_to_ms_bus = mk_bus(1'b0, 3'd0, 1'b1, 5'd3, 32'h33, 32'h1c00_0708);
        #1;
        n_cmp++; if (u_if.ms_to_ws_valid !== 1'b0) begin n_err++; $display("FAIL disc_flushed: got %b want 0", u_if.ms_to_ws_valid); end
        @(negedge clk);
        u_if.es_to_ms_valid = 1'b0;
        data_sram_data_ok   = 1'b1;
        data_sram_rdata     = 32'h1111_1111;
        #1;
        n_cmp++; if (u_if.ms_to_ws_valid !== 1'b1 || u_if.ms_to_ws_bus !== mk_ws(1'b1, 5'd3, 32'h33, 32'h1c00_0708)) begin n_err++; $display("FAIL disc_alu: got %b/%h", u_if.ms_to_ws_valid, u_if.ms_to_ws_bus); end
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        u_if.ws_allowin   = 1'b1;
        @(negedge clk);
        u_if.es_to_ms_valid = 1'b1;
        u_if.es_to_ms_bus   = mk_bus(1'b1, 3'd0, 1'b1, 5'd8, 32'h400, 32'h1c00_070c);
        @(negedge clk);
        u_if.es_to_ms_valid = 1'b0;
        data_sram_data_ok   = 1'b1;
        data_sram_rdata     = 32'hCAFE_F00D;
        #1;
        n_cmp++; if (u_if.ms_to_ws_valid !== 1'b1 || u_if.ms_to_ws_bus !== mk_ws(1'b1, 5'd8, 32'hCAFE_F00D, 32'h1c00_070c)) begin n_err++; $display("FAIL disc_cleared: got %b/%h", u_if.ms_to_ws_valid, u_if.ms_to_ws_bus); end
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        #1;
        n_cmp++; if (u_if.ms_to_ws_valid !== 1'b0) begin n_err++; $display("FAIL disc_drain: got %b want 0", u_if.ms_to_ws_valid); end
    endtask
`endif

    task automatic test_reset_mid_stall;
        @(negedge clk);
        u_if.ws_allowin     = 1'b1;
        u_if.es_to_ms_valid = 1'b1;
        u_if.es_to_ms_bus   = mk_bus(1'b1, 3'd0, 1'b1, 5'd7, 32'h100, 32'h1c00_0800);
        @(negedge clk);
        u_if.es_to_ms_valid = 1'b0;
        ms_stall            = 1'b1;
        #1;
        n_cmp++; if (ms_to_ds_forward_bus[36:32] !== 5'd7) begin n_err++; $display("FAIL rms_loaded: got dest %0d want 7", ms_to_ds_forward_bus[36:32]); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        ms_stall = 1'b0;
        #1;
        n_cmp++; if (u_if.ms_to_ws_valid !== 1'b0) begin n_err++; $display("FAIL rms_valid: got %b want 0", u_if.ms_to_ws_valid); end
        n_cmp++; if (ms_to_ds_forward_bus !== 39'd0) begin n_err++; $display("FAIL rms_fwd: got %h want 0", ms_to_ds_forward_bus); end
        n_cmp++; if (u_if.ms_allowin !== 1'b1) begin n_err++; $display("FAIL rms_allowin: got %b want 1", u_if.ms_allowin); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset               = 1'b1;
        ms_stall            = 1'b0;
        ms_flush            = 1'b0;
        data_sram_rdata     = 32'd0;
        data_sram_data_ok   = 1'b0;
        u_if.es_to_ms_valid = 1'b0;
        u_if.es_to_ms_bus   = 74'd0;
        u_if.ws_allowin     = 1'b1;
        test_reset;
        test_loads;
        test_backpressure;
        test_stall;
        test_flush;
        test_back_to_back;
`ifdef MS_DATA_OK_WAIT_EN
        test_data_ok_wait;
        test_discard;
`endif
        test_reset_mid_stall;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
